pll_rst_seq: RTL and testbench
==============================

Name: pll_rst_seq

Overview:
Consumes the PLL `pll_lock` output and produces staged, synchronous, active-high resets for the downstream clock consumers, in order: DDR3 controller, OV5640 capture, HDMI output. It runs on a free-running board clock, never on a PLL output.
- Debounces lock before releasing any stage reset.
- Re-asserts all stage resets on loss of lock.
- Pulses the PLL `RST` input if lock does not return within a timeout.

Parameters:
SYNC_STAGES, 2, flops in the `pll_lock` synchronizer (min 2)
LOCK_STABLE_CYCLES, 1024, consecutive synced-lock-high cycles required before release
N_STAGES, 3, number of stage reset outputs (min 1)
STAGE_GAP, 16, cycles between successive stage releases (min 1)
RELOCK_TIMEOUT, 65536, cycles of lock low in WAIT_LOCK before a PLL reset pulse
PLL_RST_PULSE, 8, width of the `pll_rst` pulse in cycles (min 1)

Ports:
clk  in  1  free-running board clock (50 MHz), not PLL-derived
rst  in  1  synchronous, active-high reset
pll_lock  in  1  PLL lock, asynchronous to clk
pll_rst  out  1  reset request to the PLL RST pin, active high
rst_out  out  N_STAGES  stage resets, active high; bit i is released i-th
all_released  out  1  high while all stage resets are deasserted (RUN)
lock_lost  out  1  one-cycle pulse on each loss of lock after release began
relock_count  out  8  count of lock_lost events, saturates at 255
state  out  3  0 WAIT_LOCK, 1 DEBOUNCE, 2 RELEASE, 3 RUN, 4 PLL_RST

Behaviour:
- Reset values (rst=1, applied at the clock edge):
  - state=WAIT_LOCK, rst_out all 1, pll_rst=0, all_released=0, lock_lost=0, relock_count=0.
  - Sync flops and the internal counter `cnt` are cleared.
  - rst=1 mid-operation, including mid pll_rst pulse, returns to these values at the next edge.
- Synchronizer: `lock_s` is the last flop of the SYNC_STAGES chain. It is the only source of lock information.
- `cnt` is sized internally to hold max(LOCK_STABLE_CYCLES, RELOCK_TIMEOUT, STAGE_GAP*(N_STAGES-1), PLL_RST_PULSE). It is cleared on every state change.
- All outputs are registered.
- WAIT_LOCK:
  - lock_s=1 → DEBOUNCE.
  - Otherwise cnt increments. At an edge with cnt==RELOCK_TIMEOUT-1 → PLL_RST.
- DEBOUNCE:
  - lock_s=0 → WAIT_LOCK. No lock_lost pulse, no count change.
  - lock_s=1 and cnt==LOCK_STABLE_CYCLES-1 → RELEASE; rst_out[0] goes 0 on the same edge.
  - Otherwise cnt increments.
- RELEASE:
  - rst_out[i] falls exactly STAGE_GAP*i edges after rst_out[0] falls.
  - On the edge rst_out[N_STAGES-1] falls: state=RUN and all_released=1.
  - If N_STAGES=1, DEBOUNCE goes directly to RUN with rst_out[0] and all_released on the same edge.
- RUN: holds.
- Lock loss in RELEASE or RUN (edge with lock_s=0):
  - rst_out goes all 1 and all_released goes 0.
  - lock_lost=1 for exactly one cycle.
  - relock_count increments, saturating at 255.
  - state → WAIT_LOCK.
  - Latency from the first pll_lock-low sampling edge: SYNC_STAGES edges.
- PLL_RST:
  - pll_rst=1 from the entry edge for exactly PLL_RST_PULSE cycles.
  - At the edge with cnt==PLL_RST_PULSE-1: pll_rst=0 and → WAIT_LOCK; the timeout then restarts.
  - lock_s is ignored while in PLL_RST.
  - rst_out stays all 1.
- Lock-up latency: rst_out[0] falls SYNC_STAGES+LOCK_STABLE_CYCLES edges after the first edge sampling pll_lock=1, assuming stable lock.

Test Plan:
All tests use overrides SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, N_STAGES=3, STAGE_GAP=4, RELOCK_TIMEOUT=32, PLL_RST_PULSE=4. Edge 0 is the first edge sampling the stimulus.
1. Clean lock: rst released, pll_lock rises before edge 0 → rst_out[0] falls at edge 10, rst_out[1] at 14, rst_out[2] at 18; all_released=1 and state=3 at 18; pll_rst stays 0.
2. Lock glitch during debounce: pll_lock high 5 cycles, low 1 cycle, then high → DEBOUNCE restarts; rst_out stays 3'b111 until 10 edges after the second rise; lock_lost stays 0; relock_count=0.
3. Loss in RUN: pll_lock falls before edge k → at edge k+2 rst_out=3'b111, all_released=0, lock_lost high one cycle, relock_count=1, state=0; relock resequences as in test 1.
4. Timeout: pll_lock held 0 after reset → pll_rst high from the 32nd edge for 4 cycles, low for the next 32 cycles, then high again; repeats indefinitely; rst_out=3'b111 throughout.
5. Mid-sequence reset: rst=1 during RELEASE after rst_out[0] falls, and separately during a pll_rst pulse → next edge rst_out=3'b111, pll_rst=0, state=0, relock_count=0.
6. Saturation: 256 lock-loss cycles in RUN → relock_count stops at 255; lock_lost still pulses on each loss.

Source files
------------

// File: rtl/pll_rst_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : pll_rst_seq_if
// Description : Signal bundle between the PLL lock/reset pins and the staged
//               reset sequencer. The sequencer side uses the slave modport.
//               The PLL/consumer side uses the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface pll_rst_seq_if #(
  parameter int N_STAGES = 3
);
  logic                pll_lock;
  logic                pll_rst;
  logic [N_STAGES-1:0] rst_out;
  logic                all_released;
  logic                lock_lost;
  logic [7:0]          relock_count;
  logic [2:0]          state;

  // PLL / reset-consumer side
  modport master (
    output pll_lock,
    input  pll_rst, rst_out, all_released, lock_lost, relock_count, state
  );

  // Sequencer side
  modport slave (
    input  pll_lock,
    output pll_rst, rst_out, all_released, lock_lost, relock_count, state
  );
endinterface
`default_nettype wire

// File: rtl/pll_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_rst_seq
// Description : Staged reset sequencer driven by PLL lock. It synchronizes
//               and debounces lock, then releases the stage resets one by
//               one, STAGE_GAP cycles apart. Loss of lock re-asserts all
//               stage resets. If lock stays absent for too long, the block
//               pulses the PLL reset. It runs on the free-running board
//               clock.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_rst_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int N_STAGES           = 3,
  parameter int STAGE_GAP          = 16,
  parameter int RELOCK_TIMEOUT     = 65536,
  parameter int PLL_RST_PULSE      = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  pll_rst_seq_if.slave    bus
);

  // Counter must reach the largest terminal value used by any state
  localparam int c_M0      = (LOCK_STABLE_CYCLES > RELOCK_TIMEOUT) ? LOCK_STABLE_CYCLES : RELOCK_TIMEOUT;
  localparam int c_M1      = (STAGE_GAP * (N_STAGES - 1) > PLL_RST_PULSE) ? STAGE_GAP * (N_STAGES - 1) : PLL_RST_PULSE;
  localparam int c_CNT_MAX = (c_M0 > c_M1) ? c_M0 : c_M1;
  localparam int CW        = (c_CNT_MAX < 1) ? 1 : $clog2(c_CNT_MAX + 1);

  localparam logic [CW-1:0] c_TIMEOUT_LAST = CW'(RELOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] c_STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] c_PULSE_LAST   = CW'(PLL_RST_PULSE - 1);
  localparam logic [CW-1:0] c_GAP_LAST     = CW'(STAGE_GAP * (N_STAGES - 1) - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_DEBOUNCE  = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_PLL_RST   = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;

  state_t                 r_state,        w_state_n;
  logic [CW-1:0]          r_cnt,          w_cnt_n;
  logic [N_STAGES-1:0]    r_rst_out,      w_rst_out_n;
  logic                   r_all_released, w_all_released_n;
  logic                   r_pll_rst,      w_pll_rst_n;
  logic                   r_lock_lost,    w_lock_lost_n;
  logic [7:0]             r_relock_count, w_relock_count_n;
  logic [N_STAGES-1:0]    w_rel_mask;

  // Lock synchronizer; its last flop is the only lock information used
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pll_lock};
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // Per-stage release mask: stage i drops when the release counter hits STAGE_GAP*i-1
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_rel_mask
    if (gi == 0) begin : g_first
      assign w_rel_mask[gi] = 1'b1;
    end else begin : g_rest
      localparam logic [CW-1:0] c_THR = CW'(STAGE_GAP * gi - 1);
      assign w_rel_mask[gi] = (r_cnt != c_THR);
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_WAIT_LOCK;
      r_cnt          <= '0;
      r_rst_out      <= '1;
      r_all_released <= 1'b0;
      r_pll_rst      <= 1'b0;
      r_lock_lost    <= 1'b0;
      r_relock_count <= 8'd0;
    end else begin
      r_state        <= w_state_n;
      r_cnt          <= w_cnt_n;
      r_rst_out      <= w_rst_out_n;
      r_all_released <= w_all_released_n;
      r_pll_rst      <= w_pll_rst_n;
      r_lock_lost    <= w_lock_lost_n;
      r_relock_count <= w_relock_count_n;
    end
  end

  // Next-state and next-output logic; the counter clears on every state change
  always_comb begin
    w_state_n        = r_state;
    w_cnt_n          = r_cnt + 1'b1;
    w_rst_out_n      = r_rst_out;
    w_all_released_n = r_all_released;
    w_pll_rst_n      = 1'b0;
    w_lock_lost_n    = 1'b0;
    w_relock_count_n = r_relock_count;

    case (r_state)
      S_WAIT_LOCK: begin
        w_rst_out_n      = '1;
        w_all_released_n = 1'b0;
        if (w_lock_s) begin
          w_state_n = S_DEBOUNCE;
          w_cnt_n   = '0;
        end else if (r_cnt == c_TIMEOUT_LAST) begin
          w_state_n   = S_PLL_RST;
          w_cnt_n     = '0;
          w_pll_rst_n = 1'b1;
        end
      end

      S_DEBOUNCE: begin
        if (!w_lock_s) begin
          // Glitch before release: start over silently
          w_state_n = S_WAIT_LOCK;
          w_cnt_n   = '0;
        end else if (r_cnt == c_STABLE_LAST) begin
          w_cnt_n = '0;
          if (N_STAGES == 1) begin
            w_state_n        = S_RUN;
            w_rst_out_n      = '0;
            w_all_released_n = 1'b1;
          end else begin
            w_state_n      = S_RELEASE;
            w_rst_out_n[0] = 1'b0;
          end
        end
      end

      S_RELEASE, S_RUN: begin
        if (!w_lock_s) begin
          w_state_n        = S_WAIT_LOCK;
          w_cnt_n          = '0;
          w_rst_out_n      = '1;
          w_all_released_n = 1'b0;
          w_lock_lost_n    = 1'b1;
          if (r_relock_count != 8'hFF) w_relock_count_n = r_relock_count + 8'd1;
        end else if (r_state == S_RUN) begin
          w_cnt_n = '0;
        end else begin
          w_rst_out_n = r_rst_out & w_rel_mask;
          if (r_cnt == c_GAP_LAST) begin
            w_state_n        = S_RUN;
            w_cnt_n          = '0;
            w_all_released_n = 1'b1;
          end
        end
      end

      S_PLL_RST: begin
        // Lock is ignored for the whole pulse
        w_rst_out_n = '1;
        w_pll_rst_n = 1'b1;
        if (r_cnt == c_PULSE_LAST) begin
          w_pll_rst_n = 1'b0;
          w_state_n   = S_WAIT_LOCK;
          w_cnt_n     = '0;
        end
      end

      default: begin
        w_state_n        = S_WAIT_LOCK;
        w_cnt_n          = '0;
        w_rst_out_n      = '1;
        w_all_released_n = 1'b0;
      end
    endcase
  end

  assign bus.pll_rst      = r_pll_rst;
  assign bus.rst_out      = r_rst_out;
  assign bus.all_released = r_all_released;
  assign bus.lock_lost    = r_lock_lost;
  assign bus.relock_count = r_relock_count;
  assign bus.state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_rst_seq
// Description : Directed self-checking bench for pll_rst_seq with small
//               parameters (sync 2, debounce 8, 3 stages, gap 4,
//               timeout 32, pulse 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_rst_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  pll_rst_seq_if #(.N_STAGES(3)) bus ();

  pll_rst_seq #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .N_STAGES          (3),
    .STAGE_GAP         (4),
    .RELOCK_TIMEOUT    (32),
    .PLL_RST_PULSE     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance past one active edge; outputs are stable when this returns
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pll_lock = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pll_lock = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.state); end
    n_checks++; if (bus.rst_out !== 3'b111) begin n_fail++; $display("FAIL reset_rst_out got %b want 111", bus.rst_out); end
    n_checks++; if (bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL reset_pll_rst got %b want 0", bus.pll_rst); end
    n_checks++; if (bus.all_released !== 1'b0) begin n_fail++; $display("FAIL reset_all_released got %b want 0", bus.all_released); end
    n_checks++; if (bus.lock_lost !== 1'b0) begin n_fail++; $display("FAIL reset_lock_lost got %b want 0", bus.lock_lost); end
    n_checks++; if (bus.relock_count !== 8'd0) begin n_fail++; $display("FAIL reset_relock_count got %0d want 0", bus.relock_count); end
  endtask

  task automatic test_clean_lock();
    logic [2:0] exp_rst;
    logic [2:0] exp_state;
    do_reset();
    bus.pll_lock = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      tick();
      exp_rst   = {(e < 18), (e < 14), (e < 10)};
      exp_state = (e < 2) ? 3'd0 : (e < 10) ? 3'd1 : (e < 18) ? 3'd2 : 3'd3;
      n_checks++; if (bus.rst_out !== exp_rst) begin n_fail++; $display("FAIL clean_rst_out edge %0d got %b want %b", e, bus.rst_out, exp_rst); end
      n_checks++; if (bus.state !== exp_state) begin n_fail++; $display("FAIL clean_state edge %0d got %0d want %0d", e, bus.state, exp_state); end
      n_checks++; if (bus.all_released !== (e >= 18)) begin n_fail++; $display("FAIL clean_all_released edge %0d got %b want %b", e, bus.all_released, (e >= 18)); end
      n_checks++; if (bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL clean_pll_rst edge %0d got %b want 0", e, bus.pll_rst); end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    bus.pll_lock = 1'b1;
    for (int e = 0; e <= 16; e++) begin
      tick();
      n_checks++; if (bus.lock_lost !== 1'b0) begin n_fail++; $display("FAIL glitch_lock_lost edge %0d got %b want 0", e, bus.lock_lost); end
      if (e < 16) begin
        n_checks++; if (bus.rst_out !== 3'b111) begin n_fail++; $display("FAIL glitch_rst_out edge %0d got %b want 111", e, bus.rst_out); end
      end else begin
        n_checks++; if (bus.rst_out !== 3'b110) begin n_fail++; $display("FAIL glitch_release edge %0d got %b want 110", e, bus.rst_out); end
      end
      if (e == 7) begin
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL glitch_restart_state got %0d want 0", bus.state); end
      end
      bus.pll_lock = ((e + 1) != 5);
    end
    n_checks++; if (bus.relock_count !== 8'd0) begin n_fail++; $display("FAIL glitch_relock_count got %0d want 0", bus.relock_count); end
  endtask

  task automatic test_loss_in_run();
    do_reset();
    bus.pll_lock = 1'b1;
    repeat (19) tick();
    n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL loss_pre_state got %0d want 3", bus.state); end
    bus.pll_lock = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.rst_out !== 3'b000) begin n_fail++; $display("FAIL loss_k1_rst_out got %b want 000", bus.rst_out); end
    tick();
    n_checks++; if (bus.rst_out !== 3'b111) begin n_fail++; $display("FAIL loss_rst_out got %b want 111", bus.rst_out); end
    n_checks++; if (bus.all_released !== 1'b0) begin n_fail++; $display("FAIL loss_all_released got %b want 0", bus.all_released); end
    n_checks++; if (bus.lock_lost !== 1'b1) begin n_fail++; $display("FAIL loss_lock_lost got %b want 1", bus.lock_lost); end
    n_checks++; if (bus.relock_count !== 8'd1) begin n_fail++; $display("FAIL loss_relock_count got %0d want 1", bus.relock_count); end
    n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL loss_state got %0d want 0", bus.state); end
    bus.pll_lock = 1'b1;
    tick();
    n_checks++; if (bus.lock_lost !== 1'b0) begin n_fail++; $display("FAIL loss_pulse_width got %b want 0", bus.lock_lost); end
    repeat (9) tick();
    n_checks++; if (bus.rst_out !== 3'b111) begin n_fail++; $display("FAIL relock_edge9 got %b want 111", bus.rst_out); end
    tick();
    n_checks++; if (bus.rst_out !== 3'b110) begin n_fail++; $display("FAIL relock_edge10 got %b want 110", bus.rst_out); end
    repeat (8) tick();
    n_checks++; if (bus.rst_out !== 3'b000) begin n_fail++; $display("FAIL relock_edge18 got %b want 000", bus.rst_out); end
    n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL relock_state got %0d want 3", bus.state); end
    n_checks++; if (bus.relock_count !== 8'd1) begin n_fail++; $display("FAIL relock_count_hold got %0d want 1", bus.relock_count); end
  endtask

  task automatic test_timeout();
    logic exp_p;
    do_reset();
    for (int i = 1; i <= 72; i++) begin
      tick();
      exp_p = ((i >= 32) && (i < 36)) || ((i >= 68) && (i < 72));
      n_checks++; if (bus.pll_rst !== exp_p) begin n_fail++; $display("FAIL timeout_pll_rst edge %0d got %b want %b", i, bus.pll_rst, exp_p); end
      n_checks++; if (bus.state !== (exp_p ? 3'd4 : 3'd0)) begin n_fail++; $display("FAIL timeout_state edge %0d got %0d want %0d", i, bus.state, (exp_p ? 4 : 0)); end
      n_checks++; if (bus.rst_out !== 3'b111) begin n_fail++; $display("FAIL timeout_rst_out edge %0d got %b want 111", i, bus.rst_out); end
    end
  endtask

  task automatic test_saturation();
    int t;
    logic [7:0] exp_cnt;
    do_reset();
    for (int n = 1; n <= 256; n++) begin
      bus.pll_lock = 1'b1;
      for (t = 0; t < 40; t++) begin
        tick();
        if (bus.state == 3'd3) break;
      end
      n_checks++; if (t == 40) begin n_fail++; $display("FAIL sat_reach_run loss %0d state %0d want 3", n, bus.state); end
      bus.pll_lock = 1'b0;
      for (t = 0; t < 6; t++) begin
        tick();
        if (bus.lock_lost == 1'b1) break;
      end
      n_checks++; if (t != 2) begin n_fail++; $display("FAIL sat_pulse loss %0d latency %0d want 2", n, t); end
      exp_cnt = (n > 255) ? 8'd255 : 8'(n);
      n_checks++; if (bus.relock_count !== exp_cnt) begin n_fail++; $display("FAIL sat_count loss %0d got %0d want %0d", n, bus.relock_count, exp_cnt); end
    end
  endtask

  task automatic test_mid_reset();
    int t;
    bus.pll_lock = 1'b1;
    for (t = 0; t < 40; t++) begin
      tick();
      if (bus.rst_out == 3'b110) break;
    end
    n_checks++; if (t == 40) begin n_fail++; $display("FAIL mid_reach_release got %b want 110", bus.rst_out); end
    n_checks++; if (bus.state !== 3'd2) begin n_fail++; $display("FAIL mid_release_state got %0d want 2", bus.state); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.rst_out !== 3'b111) begin n_fail++; $display("FAIL mid_rel_rst_out got %b want 111", bus.rst_out); end
    n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL mid_rel_state got %0d want 0", bus.state); end
    n_checks++; if (bus.relock_count !== 8'd0) begin n_fail++; $display("FAIL mid_rel_relock_count got %0d want 0", bus.relock_count); end
    n_checks++; if (bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL mid_rel_pll_rst got %b want 0", bus.pll_rst); end
    bus.pll_lock = 1'b0;
    for (t = 0; t < 50; t++) begin
      tick();
      if (bus.pll_rst == 1'b1) break;
    end
    n_checks++; if (t == 50) begin n_fail++; $display("FAIL mid_reach_pulse pll_rst %b want 1", bus.pll_rst); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL mid_pulse_pll_rst got %b want 0", bus.pll_rst); end
    n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL mid_pulse_state got %0d want 0", bus.state); end
    n_checks++; if (bus.rst_out !== 3'b111) begin n_fail++; $display("FAIL mid_pulse_rst_out got %b want 111", bus.rst_out); end
    n_checks++; if (bus.relock_count !== 8'd0) begin n_fail++; $display("FAIL mid_pulse_relock_count got %0d want 0", bus.relock_count); end
  endtask

  initial begin
    bus.pll_lock = 1'b0;
    test_reset();
    test_clean_lock();
    test_glitch();
    test_loss_in_run();
    test_timeout();
    test_saturation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
